// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and counter width definitions for the ALU pipeline
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_ASR = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int CNT_W = 16;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU operation and flag logic
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   sel,
    output logic [N-1:0] y,
    output logic [3:0]   flags
);

    localparam int SW = $clog2(N);

    logic [SW-1:0]  sh;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [N:0]     shl_x;
    logic [N:0]     shr_x;
    logic [N:0]     asr_x;
    logic [2*N-1:0] prod;
    logic           c;
    logic           v;
    logic           legal;

    assign sh   = b[SW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // One guard bit on each shift catches the last bit shifted out; it is 0 for a zero shift.
    assign shl_x = {1'b0, a} << sh;
    assign shr_x = {a, 1'b0} >> sh;
    assign asr_x = $signed({a, 1'b0}) >>> sh;
    assign prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};

    always_comb begin
        y     = '0;
        c     = 1'b0;
        v     = 1'b0;
        legal = 1'b1;
        case (sel)
            OP_ADD: begin
                y = sum[N-1:0];
                c = sum[N];
                v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                y = diff[N-1:0];
                c = diff[N];
                v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = shl_x[N-1:0];
                c = shl_x[N];
            end
            OP_SHR: begin
                y = shr_x[N:1];
                c = shr_x[0];
            end
            OP_ASR: begin
                y = asr_x[N:1];
                c = asr_x[0];
            end
            OP_MUL: begin
                y = prod[N-1:0];
                c = |prod[2*N-1:N];
            end
            default: legal = 1'b0;
        endcase
        flags         = '0;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_Z] = legal && (y == '0);
        flags[FLAG_N] = legal && y[N-1];
    end

endmodule

// File: rtl/alu_pipeline.sv
// rtl/alu_pipeline.sv - valid/ready ALU pipeline with global stall and operation counters
module alu_pipeline
    import alu_pkg::*;
#(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     Output,
    output logic [3:0]       flags_Output,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] stall_count
);

    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [3:0]    sel_q;
    logic [STAGES:1] v_q;
    logic [N-1:0]  y_q [2:STAGES];
    logic [3:0]    f_q [2:STAGES];
    logic [N-1:0]  core_y;
    logic [3:0]    core_f;
    logic          advance;

    assign advance      = !out_valid || out_ready;
    assign in_ready     = advance;
    assign out_valid    = v_q[STAGES];
    assign Output       = y_q[STAGES];
    assign flags_Output = f_q[STAGES];

    alu_core #(.N(N)) u_core (
        .a     (a_q),
        .b     (b_q),
        .sel   (sel_q),
        .y     (core_y),
        .flags (core_f)
    );

    // Data only loads behind a valid bit, so bubbles never disturb the held output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
            for (int i = 2; i <= STAGES; i++) begin
                y_q[i] <= '0;
                f_q[i] <= '0;
            end
        end else if (advance) begin
            v_q[1] <= in_valid;
            if (in_valid) begin
                a_q   <= A;
                b_q   <= B;
                sel_q <= Sel;
            end
            v_q[2] <= v_q[1];
            if (v_q[1]) begin
                y_q[2] <= core_y;
                f_q[2] <= core_f;
            end
            for (int i = 3; i <= STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    y_q[i] <= y_q[i-1];
                    f_q[i] <= f_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count    <= '0;
            stall_count <= '0;
        end else if (out_valid) begin
            if (out_ready) begin
                op_count <= op_count + CNT_W'(1);
            end else if (stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
